// File: rtl/fix_pkg.sv
// Shared FSM encoding and Ethernet/IPv4/TCP header layout for the FIX frame extractor.
package fix_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ETH     = 3'd1,
    ST_IP      = 3'd2,
    ST_TCP     = 3'd3,
    ST_PAYLOAD = 3'd4,
    ST_DROP    = 3'd5
  } state_e;

  localparam int ETH_HDR_LEN  = 14;
  localparam int IPV4_MIN_IHL = 5;
  localparam int TCP_MIN_DO   = 5;

  // Ethernet offset is frame-absolute; IP/TCP offsets are relative to their header start.
  localparam int ETH_TYPE_OFS  = 12;
  localparam int IP_IHL_OFS    = 0;
  localparam int IP_TLEN_OFS   = 2;
  localparam int IP_PROTO_OFS  = 9;
  localparam int TCP_DPORT_OFS = 2;
  localparam int TCP_DO_OFS    = 12;

endpackage

// File: rtl/fix_frame_extract.sv
// Walks Ethernet/IPv4/TCP headers of raw frames and forwards only the TCP payload
// of matching frames with SOF/EOF framing; non-matching frames are dropped whole.
module fix_frame_extract
  import fix_pkg::*;
#(
  parameter logic [15:0] ETHERTYPE_IPV4 = 16'h0800,
  parameter logic [7:0]  IP_PROTO_TCP   = 8'h06,
  parameter logic [15:0] DST_PORT       = 16'd5002,
  parameter int          CNT_W          = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_sof,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_sof,
  output logic       out_eof,
  output logic       drop,
  output logic [2:0] state
);

  // state   | meaning
  // IDLE    | waiting for in_sof; other bytes (padding) ignored
  // ETH     | Ethernet header, EtherType check on byte 13
  // IP      | IPv4 header incl. options, IHL/TotalLen/Protocol
  // TCP     | TCP header incl. options, dst port/DataOffset
  // PAYLOAD | forwarding payload, down-counting remaining bytes
  // DROP    | discarding bytes until the next in_sof

  localparam logic [CNT_W-1:0] IDX_MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [5:0]       hdr_q, hdr_d;
  logic [7:0]       etype_hi_q, etype_hi_d;
  logic [3:0]       ihl_q, ihl_d;
  logic [15:0]      totlen_q, totlen_d;
  logic [7:0]       port_hi_q, port_hi_d;
  logic [3:0]       do_q, do_d;
  logic [15:0]      rem_q, rem_d;
  logic             first_q, first_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_sof_q, out_sof_d;
  logic             out_eof_q, out_eof_d;
  logic             drop_q, drop_d;
  logic             abort_pl;
  logic [16:0]      plen;

  // Bit 16 set means TotalLen is shorter than the two headers.
  assign plen = {1'b0, totlen_q} - {11'd0, ihl_q, 2'b00} - {11'd0, do_q, 2'b00};

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    hdr_d       = hdr_q;
    etype_hi_d  = etype_hi_q;
    ihl_d       = ihl_q;
    totlen_d    = totlen_q;
    port_hi_d   = port_hi_q;
    do_d        = do_q;
    rem_d       = rem_q;
    first_d     = first_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    out_sof_d   = 1'b0;
    out_eof_d   = 1'b0;
    abort_pl    = 1'b0;
    if (in_valid) begin
      if (in_sof) begin
        abort_pl = (state_q == ST_PAYLOAD);
        state_d  = ST_ETH;
        idx_d    = CNT_W'(1);
        hdr_d    = '0;
      end else begin
        idx_d = idx_q + CNT_W'(1);
        hdr_d = hdr_q + 6'd1;
        case (state_q)
          ST_ETH: begin
            if (idx_q == CNT_W'(ETH_TYPE_OFS)) etype_hi_d = in_data;
            if (idx_q == CNT_W'(ETH_HDR_LEN - 1)) begin
              hdr_d   = '0;
              state_d = ({etype_hi_q, in_data} == ETHERTYPE_IPV4) ? ST_IP : ST_DROP;
            end
          end
          ST_IP: begin
            if (hdr_q == 6'(IP_IHL_OFS)) begin
              ihl_d = in_data[3:0];
              if (in_data[3:0] < 4'(IPV4_MIN_IHL)) state_d = ST_DROP;
            end
            if (hdr_q == 6'(IP_TLEN_OFS)) totlen_d[15:8] = in_data;
            if (hdr_q == 6'(IP_TLEN_OFS + 1)) totlen_d[7:0] = in_data;
            if (hdr_q == 6'(IP_PROTO_OFS) && in_data != IP_PROTO_TCP) state_d = ST_DROP;
            if (hdr_q > 6'(IP_PROTO_OFS) && hdr_q == {ihl_q, 2'b00} - 6'd1) begin
              hdr_d   = '0;
              state_d = ST_TCP;
            end
          end
          ST_TCP: begin
            if (hdr_q == 6'(TCP_DPORT_OFS)) port_hi_d = in_data;
            if (hdr_q == 6'(TCP_DPORT_OFS + 1) && DST_PORT != 16'd0 &&
                {port_hi_q, in_data} != DST_PORT) state_d = ST_DROP;
            if (hdr_q == 6'(TCP_DO_OFS)) begin
              do_d = in_data[7:4];
              if (in_data[7:4] < 4'(TCP_MIN_DO)) state_d = ST_DROP;
            end
            // Guard on > DO offset so a stale DataOffset from a previous frame cannot end early.
            if (hdr_q > 6'(TCP_DO_OFS) && hdr_q == {do_q, 2'b00} - 6'd1) begin
              hdr_d = '0;
              if (plen[16]) begin
                state_d = ST_DROP;
              end else if (plen[15:0] == 16'd0) begin
                state_d = ST_IDLE;
              end else begin
                state_d = ST_PAYLOAD;
                rem_d   = plen[15:0];
                first_d = 1'b1;
              end
            end
          end
          ST_PAYLOAD: begin
            out_valid_d = 1'b1;
            out_data_d  = in_data;
            out_sof_d   = first_q;
            first_d     = 1'b0;
            rem_d       = rem_q - 16'd1;
            if (rem_q == 16'd1) begin
              out_eof_d = 1'b1;
              state_d   = ST_IDLE;
            end
          end
          default: begin
            idx_d = idx_q;
            hdr_d = hdr_q;
          end
        endcase
        if (state_q inside {ST_ETH, ST_IP, ST_TCP, ST_PAYLOAD} && idx_q == IDX_MAX) begin
          state_d     = ST_DROP;
          out_valid_d = 1'b0;
          out_sof_d   = 1'b0;
          out_eof_d   = 1'b0;
          out_data_d  = out_data_q;
        end
      end
    end
    drop_d = abort_pl || (state_d == ST_DROP && state_q != ST_DROP);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      hdr_q       <= '0;
      etype_hi_q  <= '0;
      ihl_q       <= '0;
      totlen_q    <= '0;
      port_hi_q   <= '0;
      do_q        <= '0;
      rem_q       <= '0;
      first_q     <= 1'b0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      hdr_q       <= hdr_d;
      etype_hi_q  <= etype_hi_d;
      ihl_q       <= ihl_d;
      totlen_q    <= totlen_d;
      port_hi_q   <= port_hi_d;
      do_q        <= do_d;
      rem_q       <= rem_d;
      first_q     <= first_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      out_eof_q   <= out_eof_d;
      drop_q      <= drop_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
  assign out_eof   = out_eof_q;
  assign drop      = drop_q;
  assign state     = state_q;

endmodule

// File: tb/tb_fix_frame_extract.sv
// Directed + randomized bench for fix_frame_extract against a frame-level reference model.
module tb_fix_frame_extract;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid, in_sof;
  logic [7:0] out_data;
  logic       out_valid, out_sof, out_eof, drop;
  logic [2:0] state;

  always #5 clk = ~clk;

  fix_frame_extract dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
    .out_data(out_data), .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof),
    .drop(drop), .state(state)
  );

  int n_cmp = 0;
  int n_mis = 0;

  logic [7:0]  s_data[$];
  bit          s_sof[$];
  logic [11:0] e_out[$];   // {valid, sof, eof, drop, data}
  logic [7:0]  frm[$];
  logic [7:0]  pay_ref[$];
  logic [7:0]  cap[$];
  logic [7:0]  ref1[$];
  int obs_sof, obs_eof, obs_drop, n_drop, n_sof;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] sample();
    return {out_valid, out_sof, out_eof, drop, out_valid ? out_data : 8'h00};
  endfunction

  task automatic build_frame(logic [15:0] et, int ihl, logic [15:0] tl, logic [7:0] proto,
                             logic [15:0] port, int dof, int npay, int npad);
    int ih, th;
    logic [7:0] b;
    frm.delete();
    for (int i = 0; i < 12; i++) frm.push_back(8'($urandom));
    frm.push_back(et[15:8]);
    frm.push_back(et[7:0]);
    ih = (ihl < 5) ? 20 : 4 * ihl;
    for (int i = 0; i < ih; i++) begin
      b = 8'($urandom);
      if (i == 0) b = {4'h4, 4'(ihl)};
      if (i == 2) b = tl[15:8];
      if (i == 3) b = tl[7:0];
      if (i == 9) b = proto;
      frm.push_back(b);
    end
    th = (dof < 5) ? 20 : 4 * dof;
    for (int i = 0; i < th; i++) begin
      b = 8'($urandom);
      if (i == 2) b = port[15:8];
      if (i == 3) b = port[7:0];
      if (i == 12) b = {4'(dof), 4'h0};
      frm.push_back(b);
    end
    for (int i = 0; i < npay; i++) frm.push_back((i < pay_ref.size()) ? pay_ref[i] : 8'($urandom));
    for (int i = 0; i < npad; i++) frm.push_back(8'($urandom));
  endtask

  task automatic add_frame(int keep);
    int n;
    n = (keep > 0 && keep < frm.size()) ? keep : frm.size();
    for (int i = 0; i < n; i++) begin
      s_data.push_back(frm[i]);
      s_sof.push_back(i == 0);
    end
  endtask

  task automatic clear_stream();
    s_data.delete();
    s_sof.delete();
  endtask

  // Expected outputs of one frame occupying stream[s .. s+n-1]; returns 1 if it ends in PAYLOAD.
  function automatic bit model_frame(int s, int n);
    int ihl, dof, tl, t, e, plen, ps, pe, dropi, done;
    logic [7:0] b14, bdo;
    dropi = -1; ps = -1; pe = -1; done = -1; e = -1;
    if (n > 13) begin
      if ({s_data[s+12], s_data[s+13]} != 16'h0800) dropi = 13;
      else if (n > 14) begin
        b14 = s_data[s+14];
        ihl = int'(b14[3:0]);
        if (ihl < 5) dropi = 14;
        else if (n > 23) begin
          if (s_data[s+23] != 8'h06) dropi = 23;
          else begin
            tl = int'({s_data[s+16], s_data[s+17]});
            t  = 14 + 4 * ihl;
            if (n > t + 3) begin
              if ({s_data[s+t+2], s_data[s+t+3]} != 16'd5002) dropi = t + 3;
              else if (n > t + 12) begin
                bdo = s_data[s+t+12];
                dof = int'(bdo[7:4]);
                if (dof < 5) dropi = t + 12;
                else begin
                  e    = t + 4 * dof - 1;
                  plen = tl - 4 * ihl - 4 * dof;
                  if (plen < 0) begin
                    if (n > e) dropi = e;
                  end else if (plen == 0) done = e;
                  else begin
                    ps = e + 1; pe = e + plen; done = pe;
                  end
                end
              end
            end
          end
        end
      end
    end
    if (n > 2047 && dropi < 0 && (done < 0 || done >= 2047)) dropi = 2047;
    for (int i = 0; i < n; i++)
      if (pe >= 0 && i >= ps && i <= pe && (dropi < 0 || i < dropi))
        e_out[s+i] = {1'b1, 1'(i == ps), 1'(i == pe), 1'b0, s_data[s+i]};
    if (dropi >= 0 && dropi < n) e_out[s+dropi][8] = 1'b1;
    return (dropi < 0) && pe >= 0 && (n - 1) >= (ps - 1) && (n - 1) < pe;
  endfunction

  task automatic model_stream();
    int p, q;
    bit open;
    e_out.delete();
    for (int i = 0; i < s_data.size(); i++) e_out.push_back(12'h000);
    open = 1'b0;
    p = 0;
    while (p < s_data.size()) begin
      if (!s_sof[p]) p++;
      else begin
        q = p + 1;
        while (q < s_data.size() && !s_sof[q]) q++;
        if (open) e_out[p][8] = 1'b1;
        open = model_frame(p, q - p);
        p = q;
      end
    end
  endtask

  task automatic run_stream(int limit, int gapmode, string tag);
    logic [11:0] ob;
    model_stream();
    obs_sof = -1; obs_eof = -1; obs_drop = -1; n_drop = 0; n_sof = 0;
    cap.delete();
    for (int p = 0; p < s_data.size() && p < limit; p++) begin
      if (gapmode == 1 || (gapmode == 2 && $urandom_range(0, 3) == 0)) begin
        @(negedge clk);
        in_valid = 1'b0; in_sof = 1'b0; in_data = 8'($urandom);
        @(posedge clk); #1;
        check($sformatf("%s gap@%0d", tag, p), {20'd0, sample()}, 32'd0);
      end
      @(negedge clk);
      in_valid = 1'b1; in_sof = s_sof[p]; in_data = s_data[p];
      @(posedge clk); #1;
      ob = sample();
      check($sformatf("%s byte%0d", tag, p), {20'd0, ob}, {20'd0, e_out[p]});
      if (out_valid) cap.push_back(out_data);
      if (out_sof) begin obs_sof = p; n_sof++; end
      if (out_eof) obs_eof = p;
      if (drop) begin obs_drop = p; n_drop++; end
    end
    @(negedge clk);
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  function automatic bit same_as_ref1();
    if (cap.size() != ref1.size()) return 1'b0;
    for (int i = 0; i < cap.size(); i++) if (cap[i] !== ref1[i]) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    int ihl, dof, plen, tl, keep, npay;
    logic [15:0] et, port;
    logic [7:0]  proto;
    bit ok;

    rst = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = 8'h00;
    for (int i = 0; i < 2200; i++) pay_ref.push_back(8'($urandom));
    repeat (3) @(posedge clk);
    #1;
    check("reset out_data", {24'd0, out_data}, 32'd0);
    check("reset ctrl", {28'd0, out_valid, out_sof, out_eof, drop}, 32'd0);
    check("reset state", {29'd0, state}, 32'd0);
    @(negedge clk) rst = 1'b1;

    // T1: baseline frame
    clear_stream();
    build_frame(16'h0800, 5, 16'h00CF, 8'h06, 16'd5002, 5, 167, 0);
    add_frame(0);
    run_stream(1 << 30, 0, "T1");
    check("T1 nvalid", cap.size(), 167);
    check("T1 sof idx", obs_sof, 54);
    check("T1 eof idx", obs_eof, 220);
    check("T1 ndrop", n_drop, 0);
    ok = (cap.size() == 167);
    for (int i = 0; i < 167 && i < cap.size(); i++) if (cap[i] !== pay_ref[i]) ok = 1'b0;
    check("T1 payload", {31'd0, ok}, 32'd1);
    ref1 = cap;
    check("T1 state", {29'd0, state}, 32'd0);

    // T2: wrong EtherType
    clear_stream();
    build_frame(16'h86DD, 5, 16'h00CF, 8'h06, 16'd5002, 5, 167, 0);
    add_frame(0);
    run_stream(1 << 30, 0, "T2");
    check("T2 nvalid", cap.size(), 0);
    check("T2 ndrop", n_drop, 1);
    check("T2 drop idx", obs_drop, 13);
    check("T2 state", {29'd0, state}, 32'd5);

    // T3: IHL=6 with options
    clear_stream();
    build_frame(16'h0800, 6, 16'h00D3, 8'h06, 16'd5002, 5, 167, 0);
    add_frame(0);
    run_stream(1 << 30, 0, "T3");
    check("T3 sof idx", obs_sof, 58);
    check("T3 nvalid", cap.size(), 167);
    check("T3 payload", {31'd0, same_as_ref1()}, 32'd1);

    // T4: Ethernet padding after the datagram
    clear_stream();
    build_frame(16'h0800, 5, 16'h00CF, 8'h06, 16'd5002, 5, 167, 10);
    add_frame(0);
    run_stream(1 << 30, 0, "T4");
    check("T4 eof idx", obs_eof, 220);
    check("T4 nvalid", cap.size(), 167);
    check("T4 ndrop", n_drop, 0);

    // T5: abort at payload byte 20, then a full frame
    clear_stream();
    build_frame(16'h0800, 5, 16'h00CF, 8'h06, 16'd5002, 5, 167, 0);
    add_frame(74);
    build_frame(16'h0800, 5, 16'h00CF, 8'h06, 16'd5002, 5, 167, 0);
    add_frame(0);
    run_stream(1 << 30, 0, "T5");
    check("T5 ndrop", n_drop, 1);
    check("T5 drop idx", obs_drop, 74);
    check("T5 nsof", n_sof, 2);
    check("T5 sof idx", obs_sof, 128);
    check("T5 eof idx", obs_eof, 294);
    check("T5 nvalid", cap.size(), 187);

    // T6: reset in PAYLOAD, then a gapped frame
    clear_stream();
    build_frame(16'h0800, 5, 16'h00CF, 8'h06, 16'd5002, 5, 167, 0);
    add_frame(0);
    run_stream(100, 0, "T6a");
    rst = 1'b0;
    @(posedge clk); #1;
    check("T6 rst ctrl", {24'd0, out_data, out_valid, out_sof, out_eof, drop}, 32'd0);
    check("T6 rst state", {29'd0, state}, 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    check("T6 rst hold", {21'd0, out_data, out_valid, out_sof, out_eof, drop, state}, 32'd0);
    @(negedge clk) rst = 1'b1;
    run_stream(1 << 30, 1, "T6b");
    check("T6 nvalid", cap.size(), 167);
    check("T6 payload", {31'd0, same_as_ref1()}, 32'd1);
    check("T6 eof idx", obs_eof, 220);

    // T7: randomized headers, lengths, truncations and gaps
    clear_stream();
    for (int i = 0; i < 3; i++) begin
      s_data.push_back(8'($urandom));
      s_sof.push_back(1'b0);
    end
    for (int k = 0; k < 14; k++) begin
      et    = ($urandom_range(0, 5) == 0) ? 16'h86DD : 16'h0800;
      ihl   = ($urandom_range(0, 7) == 0) ? 4 : int'($urandom_range(5, 7));
      proto = ($urandom_range(0, 7) == 0) ? 8'h11 : 8'h06;
      port  = ($urandom_range(0, 7) == 0) ? 16'd80 : 16'd5002;
      dof   = ($urandom_range(0, 7) == 0) ? 3 : int'($urandom_range(5, 8));
      plen  = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 30));
      npay  = plen;
      tl    = 4 * ihl + 4 * dof + plen;
      if ($urandom_range(0, 7) == 0) begin
        tl   = 4 * ihl + 4 * dof - int'($urandom_range(1, 8));
        npay = 0;
      end
      build_frame(et, ihl, 16'(tl), proto, port, dof, npay, int'($urandom_range(0, 6)));
      keep = (k < 13 && $urandom_range(0, 4) == 0) ? int'($urandom_range(1, frm.size())) : 0;
      add_frame(keep);
    end
    run_stream(1 << 30, 2, "T7");

    // T8: frame longer than the byte counter
    clear_stream();
    build_frame(16'h0800, 5, 16'd3000, 8'h06, 16'd5002, 5, 2100, 0);
    add_frame(0);
    run_stream(1 << 30, 0, "T8");
    check("T8 nvalid", cap.size(), 1993);
    check("T8 ndrop", n_drop, 1);
    check("T8 drop idx", obs_drop, 2047);
    check("T8 no eof", obs_eof, -1);
    check("T8 state", {29'd0, state}, 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
